// File: rtl/trv_regfile_pkg.sv
// rtl/trv_regfile_pkg.sv - shared types and constants for the 2R1W register file
package trv_regfile_pkg;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_e;

   function automatic int regfile_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

   localparam int RF_ADDR_WIDTH_DFLT = 5;
   localparam int REGFILE_DEPTH      = regfile_depth(RF_ADDR_WIDTH_DFLT);

   // Widest entry supported; narrower files slice the low bits.
   localparam int                          RF_MAX_DATA_WIDTH = 64;
   localparam logic [RF_MAX_DATA_WIDTH-1:0] RF_ZERO_WORD     = '0;

endpackage

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - post-reset clear walker (CLEAR/RUN FSM) for the register file
module regfile_clear_seq
   import trv_regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output logic                  ready
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   rf_state_e             r_state;
   rf_state_e             w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_clr_cnt;
   logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= RF_CLEAR;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      clr_we        = 1'b0;
      clr_addr      = r_clr_cnt;
      ready         = 1'b0;
      case (r_state)
         RF_CLEAR: begin
            clr_we = 1'b1;
            // Leaving CLEAR ends the walk; the counter never wraps into a second pass.
            if (r_clr_cnt == LAST_ADDR) begin
               w_state_nxt = RF_RUN;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            end
         end
         RF_RUN: begin
            ready = 1'b1;
         end
         default: begin
            w_state_nxt = RF_CLEAR;
         end
      endcase
   end

endmodule

// File: rtl/sync_regfile_2r1w.sv
// rtl/sync_regfile_2r1w.sv - 2-read/1-write registered-read register file; REGFILE_BYPASS_EN selects write-first reads
module sync_regfile_2r1w
   import trv_regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ready,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd0_en,
   input  logic [ADDR_WIDTH-1:0] rd0_addr,
   output logic [DATA_WIDTH-1:0] rd0_data,
   input  logic                  rd1_en,
   input  logic [ADDR_WIDTH-1:0] rd1_addr,
   output logic [DATA_WIDTH-1:0] rd1_data
);

   localparam int                    DEPTH = regfile_depth(ADDR_WIDTH);
   localparam logic [DATA_WIDTH-1:0] ZERO  = RF_ZERO_WORD[DATA_WIDTH-1:0];

   logic                  w_clr_we;
   logic [ADDR_WIDTH-1:0] w_clr_addr;
   logic                  w_ready;
   logic                  w_user_we;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_rd0_val;
   logic [DATA_WIDTH-1:0] w_rd1_val;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rd0;
   logic [DATA_WIDTH-1:0] r_rd1;

   regfile_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_seq (
      .clk      (clk),
      .rst      (rst),
      .clr_we   (w_clr_we),
      .clr_addr (w_clr_addr),
      .ready    (w_ready)
   );

   // Writes to a hardwired-zero entry are dropped entirely, including for bypass.
   assign w_user_we = w_ready && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
   assign w_we      = w_clr_we || w_user_we;
   assign w_waddr   = w_clr_we ? w_clr_addr : wr_addr;
   assign w_wdata   = w_clr_we ? ZERO : wr_data;

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   always_comb begin
      w_rd0_val = r_mem[rd0_addr];
      w_rd1_val = r_mem[rd1_addr];
`ifdef REGFILE_BYPASS_EN
      if (w_user_we && (wr_addr == rd0_addr)) w_rd0_val = wr_data;
      if (w_user_we && (wr_addr == rd1_addr)) w_rd1_val = wr_data;
`endif
      if ((ZERO_REG != 0) && (rd0_addr == '0)) w_rd0_val = ZERO;
      if ((ZERO_REG != 0) && (rd1_addr == '0)) w_rd1_val = ZERO;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd0 <= ZERO;
         r_rd1 <= ZERO;
      end else begin
         if (w_ready && rd0_en) r_rd0 <= w_rd0_val;
         if (w_ready && rd1_en) r_rd1 <= w_rd1_val;
      end
   end

   assign ready    = w_ready;
   assign rd0_data = r_rd0;
   assign rd1_data = r_rd1;

endmodule
